proto_mark_cnt: RTL and testbench
=================================

# proto_mark_cnt

Parametrised successor to the single-protocol ping marker in the UM ingress path. It sits inline on the 134-bit packet stream. On each packet's metadata cycle it compares one metadata field against `NUM_RULES` programmable match values, rewrites the field with the first matching rule's mark value, and keeps per-rule and miss packet counters that software can read.

## Interface
- `DLY`, 3: input delay-line depth in cycles; legal range 1..8.
- `NUM_RULES`, 4: number of match rules; legal range 1..8.
- `FIELD_LSB`, 64: LSB of the matched/rewritten metadata field.
- `FIELD_W`, 8: width of the matched field.
- `CNT_W`, 16: width of each counter.
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `in_data`  in  134  stream word; the first word of a packet is metadata.
- `in_data_wr`  in  1  `in_data` is valid this cycle.
- `in_data_valid`  in  1  packet-end status; 1 = keep, 0 = drop.
- `in_data_valid_wr`  in  1  strobe for `in_data_valid`; marks the last word.
- `out_data`, `out_data_wr`, `out_data_valid`, `out_data_valid_wr`  out  134/1/1/1  registered output stream.
- `cfg_rule_en`  in  `NUM_RULES`  per-rule enable.
- `cfg_rule_val`  in  `NUM_RULES*FIELD_W`  match values; rule i occupies slice i.
- `cfg_rule_mark`  in  `NUM_RULES*FIELD_W`  replacement values.
- `cnt_clr`  in  1  one-cycle pulse; clears all counters.
- `cnt_rd_idx`  in  4  counter select: 0..NUM_RULES-1 = rule counters, NUM_RULES = miss counter.
- `cnt_rd_data`  out  `CNT_W`  registered selected counter.

## Operation
- All four input signals pass through a `DLY`-stage delay line, reset-free. Every decision uses the delayed word only; the undelayed input is never inspected.
- FSM states:
  - `IDLE_S` (reset state).
  - `BODY_S`.
- In `IDLE_S` with delayed `wr`=1, the word is metadata:
  - Field `[FIELD_LSB+FIELD_W-1:FIELD_LSB]` is compared against every enabled rule. Config is sampled on this cycle only.
  - On a hit, the lowest-index matching rule wins. Its mark replaces the field, all other bits pass unchanged, and its counter increments.
  - On no hit, the word passes unchanged and the miss counter increments.
  - If delayed `valid_wr`=1 on the same word (single-word packet), `out_data_valid`/`out_data_valid_wr` follow it and the FSM stays in `IDLE_S`. Otherwise the FSM goes to `BODY_S`.
- In `IDLE_S` with delayed `wr`=0: all outputs are driven to 0.
- In `BODY_S`: the delayed word, `wr` and `valid` pass through unchanged.
  - On delayed `valid_wr`=1, `out_data_valid` = delayed `valid` (including drop, `valid`=0), `out_data_valid_wr`=1, and the FSM returns to `IDLE_S`.
  - At all other times `out_data_valid` and `out_data_valid_wr` are 0.
  - Gaps (`wr`=0) inside a packet keep the state at `BODY_S`.
- Counters saturate at all-ones and never wrap.
- A `cnt_clr` coinciding with an increment loads that counter with 1; other counters load 0.
- Dropped packets remain counted; the count is per metadata word seen.

## Timing
- Stream latency: `DLY`+1 cycles from input to output, for every word.
- Counter update is visible on `cnt_rd_data` 2 cycles after the metadata word appears on `out_data`: one cycle for the counter update, one for the registered read.
- `cnt_rd_data` has 1-cycle read latency. `cnt_rd_idx` > `NUM_RULES` reads 0.
- Reset values:
  - All `out_*` = 0.
  - `cnt_rd_data` = 0.
  - All counters = 0.
  - FSM = `IDLE_S`.
- Reset mid-packet: words still in the delay line after reset release are treated from `IDLE_S`. The first delayed `wr` word is taken as metadata, which is acceptable because upstream is also reset.
- Back-to-back packets are supported: a metadata word immediately after an end word is handled with no bubble.

## Structure
- Package `proto_mark_pkg` holds:
  - FSM state encodings `IDLE_S`/`BODY_S`.
  - Bus width constant 134.
  - Counter-select width.
  - Default `FIELD_LSB`/`FIELD_W`.
- Sub-module `stream_dly_line`: a parametrised `DLY`-deep register chain carrying `{data, wr, valid, valid_wr}`.
- Rule match is a combinational priority loop. Counters are a `NUM_RULES`+1 entry register array.

## Test plan
- ICMP detection:
  - Stimulus: rule0 enabled with val=0x01, mark=0xFF; 4-word packet with field 0x01, end `valid`=1.
  - Response: output field = 0xFF, other bits unchanged, after 4 cycles; counter0 = 1, miss = 0.
- Priority:
  - Stimulus: rules 1 and 2 both val=0x06, marks 0xA1 and 0xA2.
  - Response: field 0x06 is marked 0xA1; only counter1 increments.
- Single-word plus back-to-back:
  - Stimulus: 1-word packet with `wr`=`valid_wr`=`valid`=1, immediately followed by a 3-word miss packet.
  - Response: both packets are output intact; miss = 1; FSM is in `IDLE_S` after each end word.
- Drop and gap:
  - Stimulus: packet with a 2-cycle `wr`=0 gap mid-body, ending `valid`=0.
  - Response: gap appears on the output; `out_data_valid_wr`=1 with `valid`=0; next packet's metadata is matched correctly.
- Saturation and clear:
  - Stimulus: with `CNT_W`=4, send 17 hits, then `cnt_clr` on the same cycle as a hit.
  - Response: counter holds 0xF after the 15th hit, then reads 1 after the clear.
- Reset:
  - Stimulus: assert `rst_n`=0 mid-packet.
  - Response: outputs = 0 asynchronously; counters = 0; `cnt_rd_data` = 0.

Source files
------------

// File: rtl/proto_mark_pkg.sv
// Shared types and constants for the protocol mark/count stage.
package proto_mark_pkg;

    localparam int unsigned BUS_W         = 134;
    localparam int unsigned STREAM_W      = BUS_W + 3;
    localparam int unsigned CNT_SEL_W     = 4;
    localparam int unsigned DEF_FIELD_LSB = 64;
    localparam int unsigned DEF_FIELD_W   = 8;

    typedef enum logic {
        IDLE_S = 1'b0,
        BODY_S = 1'b1
    } state_t;

    typedef struct packed {
        logic [BUS_W-1:0] data;
        logic             wr;
        logic             valid;
        logic             valid_wr;
    } stream_t;

endpackage

// File: rtl/stream_dly_line.sv
// Reset-free DLY-deep register chain for the {data, wr, valid, valid_wr} stream.
module stream_dly_line
    import proto_mark_pkg::*;
#(
    parameter int unsigned DLY = 3
) (
    input  logic                clk,
    input  logic [STREAM_W-1:0] din,
    output logic [STREAM_W-1:0] dout
);

    logic [STREAM_W-1:0] stage [DLY];

    always_ff @(posedge clk) begin
        stage[0] <= din;
        for (int unsigned i = 1; i < DLY; i++) begin
            stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DLY-1];

endmodule

// File: rtl/proto_mark_cnt.sv
// Inline metadata field matcher/re-marker with per-rule and miss packet counters.
module proto_mark_cnt
    import proto_mark_pkg::*;
#(
    parameter int unsigned DLY       = 3,
    parameter int unsigned NUM_RULES = 4,
    parameter int unsigned FIELD_LSB = DEF_FIELD_LSB,
    parameter int unsigned FIELD_W   = DEF_FIELD_W,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [BUS_W-1:0]             in_data,
    input  logic                         in_data_wr,
    input  logic                         in_data_valid,
    input  logic                         in_data_valid_wr,
    output logic [BUS_W-1:0]             out_data,
    output logic                         out_data_wr,
    output logic                         out_data_valid,
    output logic                         out_data_valid_wr,
    input  logic [NUM_RULES-1:0]         cfg_rule_en,
    input  logic [NUM_RULES*FIELD_W-1:0] cfg_rule_val,
    input  logic [NUM_RULES*FIELD_W-1:0] cfg_rule_mark,
    input  logic                         cnt_clr,
    input  logic [CNT_SEL_W-1:0]         cnt_rd_idx,
    output logic [CNT_W-1:0]             cnt_rd_data
);

    localparam int unsigned NUM_CNT = NUM_RULES + 1;
    localparam int unsigned IDX_W   = $clog2(NUM_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [STREAM_W-1:0] din_bits;
    logic [STREAM_W-1:0] dly_bits;
    stream_t             dly;

    assign din_bits = {in_data, in_data_wr, in_data_valid, in_data_valid_wr};
    assign dly      = stream_t'(dly_bits);

    stream_dly_line #(.DLY(DLY)) u_dly (
        .clk  (clk),
        .din  (din_bits),
        .dout (dly_bits)
    );

    // Priority match: lowest-index enabled rule wins.
    logic               hit_c;
    logic [IDX_W-1:0]   hit_idx_c;
    logic [FIELD_W-1:0] field_c;
    logic [FIELD_W-1:0] mark_c;

    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        mark_c    = '0;
        field_c   = dly.data[FIELD_LSB +: FIELD_W];
        for (int unsigned i = 0; i < NUM_RULES; i++) begin
            if (!hit_c && cfg_rule_en[i] && (cfg_rule_val[i*FIELD_W +: FIELD_W] == field_c)) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
                mark_c    = cfg_rule_mark[i*FIELD_W +: FIELD_W];
            end
        end
    end

    state_t           state;
    state_t           state_nxt;
    logic [BUS_W-1:0] data_nxt;
    logic             wr_nxt;
    logic             valid_nxt;
    logic             valid_wr_nxt;
    logic             inc_nxt;
    logic [IDX_W-1:0] inc_idx_nxt;
    logic             inc_q;
    logic [IDX_W-1:0] inc_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE_S;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        data_nxt     = '0;
        wr_nxt       = 1'b0;
        valid_nxt    = 1'b0;
        valid_wr_nxt = 1'b0;
        inc_nxt      = 1'b0;
        inc_idx_nxt  = '0;
        case (state)
            IDLE_S: begin
                if (dly.wr) begin
                    data_nxt = dly.data;
                    wr_nxt   = 1'b1;
                    inc_nxt  = 1'b1;
                    if (hit_c) begin
                        data_nxt[FIELD_LSB +: FIELD_W] = mark_c;
                        inc_idx_nxt = hit_idx_c;
                    end else begin
                        inc_idx_nxt = IDX_W'(NUM_RULES);
                    end
                    if (dly.valid_wr) begin
                        valid_nxt    = dly.valid;
                        valid_wr_nxt = 1'b1;
                    end else begin
                        state_nxt = BODY_S;
                    end
                end
            end
            BODY_S: begin
                data_nxt = dly.data;
                wr_nxt   = dly.wr;
                if (dly.valid_wr) begin
                    valid_nxt    = dly.valid;
                    valid_wr_nxt = 1'b1;
                    state_nxt    = IDLE_S;
                end
            end
            default: state_nxt = IDLE_S;
        endcase
    end

    // Output stream plus a one-cycle-delayed counter increment request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data          <= '0;
            out_data_wr       <= 1'b0;
            out_data_valid    <= 1'b0;
            out_data_valid_wr <= 1'b0;
            inc_q             <= 1'b0;
            inc_idx_q         <= '0;
        end else begin
            out_data          <= data_nxt;
            out_data_wr       <= wr_nxt;
            out_data_valid    <= valid_nxt;
            out_data_valid_wr <= valid_wr_nxt;
            inc_q             <= inc_nxt;
            inc_idx_q         <= inc_idx_nxt;
        end
    end

    // Saturating counters; a clear that meets an increment leaves that counter at 1.
    logic [CNT_W-1:0] cnt [NUM_CNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                if (cnt_clr) begin
                    cnt[i] <= (inc_q && (inc_idx_q == IDX_W'(i))) ? CNT_W'(1) : '0;
                end else if (inc_q && (inc_idx_q == IDX_W'(i)) && (cnt[i] != CNT_MAX)) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    logic [CNT_W-1:0] rd_c;

    always_comb begin
        rd_c = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (cnt_rd_idx == CNT_SEL_W'(i)) begin
                rd_c = cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_rd_data <= '0;
        end else begin
            cnt_rd_data <= rd_c;
        end
    end

endmodule

// File: tb/tb_proto_mark_cnt.sv
// Directed self-checking bench for proto_mark_cnt (DLY=3, 4 rules, 4-bit counters).
module tb_proto_mark_cnt;

    localparam int unsigned NR = 4;
    localparam int unsigned CW = 4;
    localparam int LOG_N = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [133:0]   in_data;
    logic           in_data_wr, in_data_valid, in_data_valid_wr;
    logic [133:0]   out_data;
    logic           out_data_wr, out_data_valid, out_data_valid_wr;
    logic [NR-1:0]  cfg_rule_en;
    logic [NR*8-1:0] cfg_rule_val, cfg_rule_mark;
    logic           cnt_clr;
    logic [3:0]     cnt_rd_idx;
    logic [CW-1:0]  cnt_rd_data;

    proto_mark_cnt #(.DLY(3), .NUM_RULES(NR), .FIELD_LSB(64), .FIELD_W(8), .CNT_W(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_data           (in_data),
        .in_data_wr        (in_data_wr),
        .in_data_valid     (in_data_valid),
        .in_data_valid_wr  (in_data_valid_wr),
        .out_data          (out_data),
        .out_data_wr       (out_data_wr),
        .out_data_valid    (out_data_valid),
        .out_data_valid_wr (out_data_valid_wr),
        .cfg_rule_en       (cfg_rule_en),
        .cfg_rule_val      (cfg_rule_val),
        .cfg_rule_mark     (cfg_rule_mark),
        .cnt_clr           (cnt_clr),
        .cnt_rd_idx        (cnt_rd_idx),
        .cnt_rd_data       (cnt_rd_data)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Per-cycle output log: {data, wr, valid, valid_wr}, sampled on the falling edge.
    logic [136:0]  lg     [LOG_N];
    logic [CW-1:0] lg_cnt [LOG_N];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            lg[cyc]     = {out_data, out_data_wr, out_data_valid, out_data_valid_wr};
            lg_cnt[cyc] = cnt_rd_data;
        end
    end

    function automatic logic [133:0] mkw(input logic [7:0] f, input logic [31:0] tag);
        logic [133:0] w;
        w = {6'h15, tag, 32'hA5A5_5A5A, 32'h0F0F_1234, 32'hDEAD_BEEF};
        w[71:64] = f;
        return w;
    endfunction

    task automatic drive(input logic [133:0] d, input logic w, input logic v, input logic vw);
        @(posedge clk); #1;
        in_data = d; in_data_wr = w; in_data_valid = v; in_data_valid_wr = vw;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] idx, output logic [CW-1:0] val);
        @(posedge clk); #1 cnt_rd_idx = idx;
        @(posedge clk);
        @(negedge clk);
        val = cnt_rd_data;
    endtask

    task automatic clear_cnt();
        @(posedge clk); #1 cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_data = '0; in_data_wr = 0; in_data_valid = 0; in_data_valid_wr = 0;
        cfg_rule_en = '0; cfg_rule_val = '0; cfg_rule_mark = '0;
        cnt_clr = 0; cnt_rd_idx = '0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({out_data, out_data_wr, out_data_valid, out_data_valid_wr} !== 137'd0) begin
            n_fail++; $display("FAIL reset_out: got %h exp 0", {out_data, out_data_wr, out_data_valid, out_data_valid_wr});
        end
        n_tests++;
        if (cnt_rd_data !== '0) begin n_fail++; $display("FAIL reset_rd: got %h exp 0", cnt_rd_data); end
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_icmp();
        int s;
        logic [CW-1:0] v;
        logic [133:0] b1, b2, b3;
        b1 = mkw(8'h11, 32'h100); b2 = mkw(8'h22, 32'h101); b3 = mkw(8'h33, 32'h102);
        cfg_rule_en = 4'b0001; cfg_rule_val = {8'h00, 8'h00, 8'h00, 8'h01};
        cfg_rule_mark = {8'h00, 8'h00, 8'h00, 8'hFF};
        cnt_rd_idx = 4'd0;
        clear_cnt();
        idle(2);
        drive(mkw(8'h01, 32'h1), 1, 0, 0); s = cyc;
        drive(b1, 1, 0, 0); drive(b2, 1, 0, 0); drive(b3, 1, 1, 1);
        idle(8);
        n_tests++;
        if (lg[s+4] !== {mkw(8'hFF, 32'h1), 3'b100}) begin n_fail++; $display("FAIL icmp_meta: got %h exp %h", lg[s+4], {mkw(8'hFF, 32'h1), 3'b100}); end
        n_tests++;
        if (lg[s+5] !== {b1, 3'b100}) begin n_fail++; $display("FAIL icmp_body: got %h exp %h", lg[s+5], {b1, 3'b100}); end
        n_tests++;
        if (lg[s+7] !== {b3, 3'b111}) begin n_fail++; $display("FAIL icmp_end: got %h exp %h", lg[s+7], {b3, 3'b111}); end
        n_tests++;
        if (lg_cnt[s+5] !== 4'd0 || lg_cnt[s+6] !== 4'd1) begin
            n_fail++; $display("FAIL icmp_cnt_latency: got %h,%h exp 0,1", lg_cnt[s+5], lg_cnt[s+6]);
        end
        rd(4'd4, v);
        n_tests++;
        if (v !== 4'd0) begin n_fail++; $display("FAIL icmp_miss: got %h exp 0", v); end
    endtask

    task automatic test_priority();
        int s;
        logic [CW-1:0] v;
        cfg_rule_en = 4'b0111; cfg_rule_val = {8'h77, 8'h06, 8'h06, 8'h01};
        cfg_rule_mark = {8'hA3, 8'hA2, 8'hA1, 8'hFF};
        clear_cnt();
        idle(2);
        drive(mkw(8'h06, 32'h2), 1, 0, 0); s = cyc;
        drive(mkw(8'h44, 32'h200), 1, 1, 1);
        idle(8);
        n_tests++;
        if (lg[s+4] !== {mkw(8'hA1, 32'h2), 3'b100}) begin n_fail++; $display("FAIL prio_meta: got %h exp %h", lg[s+4], {mkw(8'hA1, 32'h2), 3'b100}); end
        rd(4'd1, v);
        n_tests++;
        if (v !== 4'd1) begin n_fail++; $display("FAIL prio_cnt1: got %h exp 1", v); end
        rd(4'd2, v);
        n_tests++;
        if (v !== 4'd0) begin n_fail++; $display("FAIL prio_cnt2: got %h exp 0", v); end
        rd(4'd0, v);
        n_tests++;
        if (v !== 4'd0) begin n_fail++; $display("FAIL prio_cnt0: got %h exp 0", v); end
    endtask

    task automatic test_back_to_back();
        int s;
        logic [CW-1:0] v;
        logic [133:0] b1, b2;
        b1 = mkw(8'h01, 32'h300); b2 = mkw(8'h06, 32'h301);
        clear_cnt();
        idle(2);
        drive(mkw(8'h01, 32'h3), 1, 1, 1); s = cyc;
        drive(mkw(8'h77, 32'h4), 1, 0, 0);
        drive(b1, 1, 0, 0);
        drive(b2, 1, 1, 1);
        drive(mkw(8'h06, 32'h5), 1, 1, 1);
        idle(8);
        n_tests++;
        if (lg[s+4] !== {mkw(8'hFF, 32'h3), 3'b111}) begin n_fail++; $display("FAIL b2b_single: got %h exp %h", lg[s+4], {mkw(8'hFF, 32'h3), 3'b111}); end
        n_tests++;
        if (lg[s+5] !== {mkw(8'h77, 32'h4), 3'b100}) begin n_fail++; $display("FAIL b2b_miss_meta: got %h exp %h", lg[s+5], {mkw(8'h77, 32'h4), 3'b100}); end
        n_tests++;
        if (lg[s+6] !== {b1, 3'b100}) begin n_fail++; $display("FAIL b2b_body_unmarked: got %h exp %h", lg[s+6], {b1, 3'b100}); end
        n_tests++;
        if (lg[s+7] !== {b2, 3'b111}) begin n_fail++; $display("FAIL b2b_end: got %h exp %h", lg[s+7], {b2, 3'b111}); end
        n_tests++;
        if (lg[s+8] !== {mkw(8'hA1, 32'h5), 3'b111}) begin n_fail++; $display("FAIL b2b_next_meta: got %h exp %h", lg[s+8], {mkw(8'hA1, 32'h5), 3'b111}); end
        rd(4'd4, v);
        n_tests++;
        if (v !== 4'd1) begin n_fail++; $display("FAIL b2b_miss: got %h exp 1", v); end
        rd(4'd0, v);
        n_tests++;
        if (v !== 4'd1) begin n_fail++; $display("FAIL b2b_cnt0: got %h exp 1", v); end
        rd(4'd5, v);
        n_tests++;
        if (v !== 4'd0) begin n_fail++; $display("FAIL rd_out_of_range: got %h exp 0", v); end
    endtask

    task automatic test_drop_gap();
        int s;
        logic [CW-1:0] v;
        logic [133:0] b1, b2, b3;
        b1 = mkw(8'h06, 32'h600); b2 = mkw(8'h01, 32'h601); b3 = mkw(8'h99, 32'h602);
        clear_cnt();
        idle(2);
        drive(mkw(8'h06, 32'h6), 1, 0, 0); s = cyc;
        drive(b1, 1, 0, 0);
        idle(2);
        drive(b2, 1, 0, 0);
        drive(b3, 1, 0, 1);
        drive(mkw(8'h01, 32'h7), 1, 1, 1);
        idle(8);
        n_tests++;
        if (lg[s+4] !== {mkw(8'hA1, 32'h6), 3'b100}) begin n_fail++; $display("FAIL gap_meta: got %h exp %h", lg[s+4], {mkw(8'hA1, 32'h6), 3'b100}); end
        n_tests++;
        if (lg[s+6] !== 137'd0 || lg[s+7] !== 137'd0) begin n_fail++; $display("FAIL gap_hole: got %h / %h exp 0", lg[s+6], lg[s+7]); end
        n_tests++;
        if (lg[s+8] !== {b2, 3'b100}) begin n_fail++; $display("FAIL gap_body_after: got %h exp %h", lg[s+8], {b2, 3'b100}); end
        n_tests++;
        if (lg[s+9] !== {b3, 3'b101}) begin n_fail++; $display("FAIL drop_end: got %h exp %h", lg[s+9], {b3, 3'b101}); end
        n_tests++;
        if (lg[s+10] !== {mkw(8'hFF, 32'h7), 3'b111}) begin n_fail++; $display("FAIL drop_next_meta: got %h exp %h", lg[s+10], {mkw(8'hFF, 32'h7), 3'b111}); end
        rd(4'd1, v);
        n_tests++;
        if (v !== 4'd1) begin n_fail++; $display("FAIL drop_cnt1: got %h exp 1", v); end
        rd(4'd0, v);
        n_tests++;
        if (v !== 4'd1) begin n_fail++; $display("FAIL drop_cnt0: got %h exp 1", v); end
    endtask

    task automatic test_sat_clr();
        logic [CW-1:0] v;
        clear_cnt();
        idle(2);
        drive(mkw(8'h55, 32'h8), 1, 1, 1);
        for (int i = 0; i < 15; i++) drive(mkw(8'h01, 32'h9), 1, 1, 1);
        idle(8);
        rd(4'd0, v);
        n_tests++;
        if (v !== 4'hF) begin n_fail++; $display("FAIL sat_15: got %h exp f", v); end
        drive(mkw(8'h01, 32'h9), 1, 1, 1);
        drive(mkw(8'h01, 32'h9), 1, 1, 1);
        idle(8);
        rd(4'd0, v);
        n_tests++;
        if (v !== 4'hF) begin n_fail++; $display("FAIL sat_17: got %h exp f", v); end
        rd(4'd4, v);
        n_tests++;
        if (v !== 4'd1) begin n_fail++; $display("FAIL sat_miss: got %h exp 1", v); end
        // Hit driven in cycle s updates its counter at the edge ending cycle s+4.
        drive(mkw(8'h01, 32'hA), 1, 1, 1);
        idle(3);
        @(posedge clk); #1 cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        idle(6);
        rd(4'd0, v);
        n_tests++;
        if (v !== 4'd1) begin n_fail++; $display("FAIL clr_with_hit: got %h exp 1", v); end
        rd(4'd4, v);
        n_tests++;
        if (v !== 4'd0) begin n_fail++; $display("FAIL clr_miss: got %h exp 0", v); end
    endtask

    task automatic test_reset_mid();
        int s;
        logic [CW-1:0] v;
        cnt_rd_idx = 4'd0;
        drive(mkw(8'h01, 32'hB), 1, 0, 0);
        for (int i = 0; i < 5; i++) drive(mkw(8'h3C, 32'hB00 + 32'(i)), 1, 0, 0);
        #2 rst_n = 1'b0;
        in_data = '0; in_data_wr = 0; in_data_valid = 0; in_data_valid_wr = 0;
        #1;
        n_tests++;
        if ({out_data, out_data_wr, out_data_valid, out_data_valid_wr} !== 137'd0) begin
            n_fail++; $display("FAIL rst_mid_out: got %h exp 0", {out_data, out_data_wr, out_data_valid, out_data_valid_wr});
        end
        n_tests++;
        if (cnt_rd_data !== '0) begin n_fail++; $display("FAIL rst_mid_rd: got %h exp 0", cnt_rd_data); end
        repeat (6) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        rd(4'd0, v);
        n_tests++;
        if (v !== 4'd0) begin n_fail++; $display("FAIL rst_cnt0: got %h exp 0", v); end
        rd(4'd4, v);
        n_tests++;
        if (v !== 4'd0) begin n_fail++; $display("FAIL rst_miss: got %h exp 0", v); end
        drive(mkw(8'h06, 32'hC), 1, 1, 1); s = cyc;
        idle(8);
        n_tests++;
        if (lg[s+4] !== {mkw(8'hA1, 32'hC), 3'b111}) begin n_fail++; $display("FAIL rst_after_meta: got %h exp %h", lg[s+4], {mkw(8'hA1, 32'hC), 3'b111}); end
        rd(4'd1, v);
        n_tests++;
        if (v !== 4'd1) begin n_fail++; $display("FAIL rst_after_cnt1: got %h exp 1", v); end
    endtask

    initial begin
        test_reset();
        test_icmp();
        test_priority();
        test_back_to_back();
        test_drop_gap();
        test_sat_clr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
